// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/exception vectors,
// the fetch FSM encoding and the bubble instruction word.
package cpu_defs;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: exception target, then a pending branch redirect,
// then sequential pc+4 (wraps at 32 bits).
module fetch_next_pc #(
    parameter logic [31:0] EXC_ENTRY = cpu_defs::EXC_ENTRY
) (
    input  logic [31:0] i_pc,
    input  logic        i_exc,
    input  logic        i_exc_sel,
    input  logic [31:0] i_exc_pc,
    input  logic        i_redir_go,
    input  logic [31:0] i_redir_pc,
    output logic [31:0] o_next_pc,
    output logic        o_redirect
);

    always_comb begin
        o_next_pc  = i_pc + 32'd4;
        o_redirect = 1'b0;
        if (i_exc) begin
            o_next_pc  = i_exc_sel ? i_exc_pc : EXC_ENTRY;
            o_redirect = 1'b1;
        end else if (i_redir_go) begin
            o_next_pc  = i_redir_pc;
            o_redirect = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: owns the PC, issues one instruction-bus request at a time and
// presents fetched instructions to decode, honouring stalls and redirects.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
    parameter logic [31:0] EXC_ENTRY = cpu_defs::EXC_ENTRY
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallF,
    input  logic        branch_takenD,
    input  logic [31:0] branch_targetD,
    input  logic        is_branchD,
    input  logic        exceptM,
    input  logic        except_pc_sel,
    input  logic [31:0] except_pcM,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instrF,
    output logic        instr_validF,
    output logic [31:0] F_change,
    output logic        addr_errF,
    output logic [1:0]  o_dbg_state
);
    import cpu_defs::*;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_discard, w_discard_nxt;
    logic         r_dslot_cap, w_dslot_cap_nxt;
    logic         r_redir_pend, w_redir_pend_nxt;
    logic [31:0]  r_redir_pc, w_redir_pc_nxt;
    logic [31:0]  r_pcF, w_pcF_nxt;
    logic [31:0]  r_pc4F, w_pc4F_nxt;
    logic [31:0]  r_instrF, w_instrF_nxt;
    logic         r_validF, w_validF_nxt;
    logic         r_fchg, w_fchg_nxt;
    logic         r_aerrF, w_aerrF_nxt;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_next_pc;
    logic         w_redirect;
    logic         w_misalign;
    logic         w_dslot_done;
    logic         w_redir_go;
    logic         w_advance;
    logic         w_step;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_misalign   = (r_pc[1:0] != 2'b00);
    // The instruction whose completion releases the PC is the delay slot when
    // its request was accepted with is_branchD high.
    assign w_dslot_done = (r_state == S_HOLD) ? r_fchg : r_dslot_cap;
    assign w_redir_go   = r_redir_pend && w_dslot_done;
    assign w_step       = exceptM || w_advance;

    fetch_next_pc #(
        .EXC_ENTRY (EXC_ENTRY)
    ) u_next_pc (
        .i_pc       (r_pc),
        .i_exc      (exceptM),
        .i_exc_sel  (except_pc_sel),
        .i_exc_pc   (except_pcM),
        .i_redir_go (w_redir_go),
        .i_redir_pc (r_redir_pc),
        .o_next_pc  (w_next_pc),
        .o_redirect (w_redirect)
    );

    // Bus handshake: a request is accepted in any cycle with inst_req && inst_addr_ok;
    // exactly one inst_data_ok follows, and no new request is raised before it.
    always_comb begin
        w_state_nxt     = r_state;
        w_discard_nxt   = r_discard;
        w_dslot_cap_nxt = r_dslot_cap;
        w_pcF_nxt       = r_pcF;
        w_pc4F_nxt      = r_pc4F;
        w_instrF_nxt    = r_instrF;
        w_validF_nxt    = r_validF;
        w_fchg_nxt      = r_fchg;
        w_aerrF_nxt     = r_aerrF;
        w_advance       = 1'b0;
        inst_req        = 1'b0;

        case (r_state)
            S_REQ: begin
                inst_req     = resetn && !w_misalign && !exceptM;
                w_validF_nxt = 1'b0;
                w_instrF_nxt = INSTR_NOP;
                w_fchg_nxt   = 1'b0;
                w_aerrF_nxt  = 1'b0;
                if (!exceptM) begin
                    if (w_misalign) begin
                        w_pcF_nxt   = r_pc;
                        w_pc4F_nxt  = w_pc_plus4;
                        w_aerrF_nxt = 1'b1;
                    end else if (inst_addr_ok) begin
                        w_state_nxt     = S_WAIT;
                        w_dslot_cap_nxt = is_branchD;
                    end
                end
            end
            S_WAIT: begin
                w_validF_nxt = 1'b0;
                w_instrF_nxt = INSTR_NOP;
                w_fchg_nxt   = 1'b0;
                w_aerrF_nxt  = 1'b0;
                if (inst_data_ok) begin
                    w_discard_nxt = 1'b0;
                    w_state_nxt   = S_REQ;
                    if (!r_discard && !exceptM) begin
                        w_pcF_nxt    = r_pc;
                        w_pc4F_nxt   = w_pc_plus4;
                        w_instrF_nxt = inst_rdata;
                        w_validF_nxt = 1'b1;
                        w_fchg_nxt   = r_dslot_cap;
                        if (stallF) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end else if (exceptM) begin
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (exceptM || !stallF) begin
                    w_validF_nxt = 1'b0;
                    w_instrF_nxt = INSTR_NOP;
                    w_fchg_nxt   = 1'b0;
                    w_aerrF_nxt  = 1'b0;
                    w_state_nxt  = S_REQ;
                    w_advance    = !exceptM;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase

        w_pc_nxt = w_step ? w_next_pc : r_pc;

        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;
        if (exceptM) begin
            w_redir_pend_nxt = 1'b0;
        end else if (branch_takenD && !stallF) begin
            w_redir_pend_nxt = 1'b1;
            w_redir_pc_nxt   = branch_targetD;
        end else if (w_advance && w_redirect) begin
            w_redir_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_discard    <= 1'b0;
            r_dslot_cap  <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'd0;
            r_pcF        <= 32'd0;
            r_pc4F       <= 32'd0;
            r_instrF     <= INSTR_NOP;
            r_validF     <= 1'b0;
            r_fchg       <= 1'b0;
            r_aerrF      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_dslot_cap  <= w_dslot_cap_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_pcF        <= w_pcF_nxt;
            r_pc4F       <= w_pc4F_nxt;
            r_instrF     <= w_instrF_nxt;
            r_validF     <= w_validF_nxt;
            r_fchg       <= w_fchg_nxt;
            r_aerrF      <= w_aerrF_nxt;
        end
    end

    assign inst_addr    = r_pc;
    assign pcF          = r_pcF;
    assign pc_plus4F    = r_pc4F;
    assign instrF       = r_instrF;
    assign instr_validF = r_validF;
    assign F_change     = {31'd0, r_fchg};
    assign addr_errF    = r_aerrF;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: bus slave model with programmable
// data latency, vector table for straight-line fetches, directed redirect cases.
module tb_fetch_pc_unit;
    import cpu_defs::*;

    logic        clk;
    logic        resetn;
    logic        stallF;
    logic        branch_takenD;
    logic [31:0] branch_targetD;
    logic        is_branchD;
    logic        exceptM;
    logic        except_pc_sel;
    logic [31:0] except_pcM;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic [31:0] instrF;
    logic        instr_validF;
    logic [31:0] F_change;
    logic        addr_errF;
    logic [1:0]  o_dbg_state;

    int checks;
    int failures;

    logic [64:0] exp_q[$];
    logic [31:0] req_q[$];
    logic [64:0] mon_e;
    logic        prev_valid;

    logic        addr_ok_en;
    int          data_delay;
    logic        bus_busy;
    int          bus_cnt;
    logic [31:0] bus_addr;

    typedef struct {
        int          delay;
        int          stall;
        logic [31:0] pc;
        logic [31:0] next;
    } vec_t;
    vec_t vecs[4];

    fetch_pc_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .stallF         (stallF),
        .branch_takenD  (branch_takenD),
        .branch_targetD (branch_targetD),
        .is_branchD     (is_branchD),
        .exceptM        (exceptM),
        .except_pc_sel  (except_pc_sel),
        .except_pcM     (except_pcM),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .pcF            (pcF),
        .pc_plus4F      (pc_plus4F),
        .instrF         (instrF),
        .instr_validF   (instr_validF),
        .F_change       (F_change),
        .addr_errF      (addr_errF),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- bus slave model ----------------
    assign inst_addr_ok = inst_req && addr_ok_en;
    assign inst_data_ok = bus_busy && (bus_cnt == 1);
    assign inst_rdata   = inst_data_ok ? instr_of(bus_addr) : 32'hFFFF_FFFF;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_busy <= 1'b0;
            bus_cnt  <= 0;
            bus_addr <= 32'd0;
        end else if (inst_req && inst_addr_ok) begin
            bus_busy <= 1'b1;
            bus_cnt  <= data_delay;
            bus_addr <= inst_addr;
        end else if (bus_busy) begin
            if (bus_cnt == 1) bus_busy <= 1'b0;
            bus_cnt <= bus_cnt - 1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Scoreboard: presented instructions and accepted request addresses.
    always @(negedge clk) begin
        if (resetn && instr_validF && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr: got pc %08h required none", pcF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("f_pc", pcF, mon_e[64:33]);
                chk("f_pc4", pc_plus4F, mon_e[64:33] + 32'd4);
                chk("f_instr", instrF, mon_e[32:1]);
                chk("f_change", F_change, {31'd0, mon_e[0]});
                chk("f_aerr", 32'(addr_errF), 32'd0);
            end
        end
        if (resetn && inst_req && inst_addr_ok) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got addr %08h required none", inst_addr);
            end else begin
                chk("req_addr", inst_addr, req_q.pop_front());
            end
        end
        prev_valid <= resetn ? instr_validF : 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_data_ok();
        int n;
        n = 0;
        while (!inst_data_ok && n < 20) begin
            tick();
            n++;
        end
        chk("data_ok_timeout", 32'(inst_data_ok), 32'd1);
    endtask

    task automatic pulse_exc(input logic sel, input logic [31:0] epc, input logic tkn, input logic [31:0] tgt);
        exceptM        = 1'b1;
        except_pc_sel  = sel;
        except_pcM     = epc;
        branch_takenD  = tkn;
        branch_targetD = tgt;
        tick();
        exceptM       = 1'b0;
        branch_takenD = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int delay, input int stall,
                            input logic isb, input logic tkn, input logic [31:0] tgt);
        exp_q.push_back({pc, instr_of(pc), isb});
        req_q.push_back(pc);
        data_delay     = delay;
        addr_ok_en     = 1'b1;
        is_branchD     = isb;
        branch_takenD  = tkn;
        branch_targetD = tgt;
        tick();
        addr_ok_en    = 1'b0;
        is_branchD    = 1'b0;
        branch_takenD = 1'b0;
        wait_data_ok();
        stallF = (stall > 0);
        tick();
        for (int k = 0; k < stall; k++) begin
            chk("hold_req", 32'(inst_req), 32'd0);
            chk("hold_valid", 32'(instr_validF), 32'd1);
            chk("hold_pc", pcF, pc);
            chk("hold_instr", instrF, instr_of(pc));
            if (k == stall - 1) stallF = 1'b0;
            tick();
        end
    endtask

    // ---------------- test ----------------
    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{1, 0, 32'hBFC0_0000, 32'hBFC0_0004};
        vecs[1] = '{1, 3, 32'hBFC0_0004, 32'hBFC0_0008};
        vecs[2] = '{3, 0, 32'hBFC0_0008, 32'hBFC0_000C};
        vecs[3] = '{2, 1, 32'hBFC0_000C, 32'hBFC0_0010};

        resetn = 1'b0;
        stallF = 1'b0;
        branch_takenD = 1'b0;
        branch_targetD = 32'd0;
        is_branchD = 1'b0;
        exceptM = 1'b0;
        except_pc_sel = 1'b0;
        except_pcM = 32'd0;
        addr_ok_en = 1'b0;
        data_delay = 1;
        prev_valid = 1'b0;

        tick();
        tick();
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_valid", 32'(instr_validF), 32'd0);
        chk("rst_pcF", pcF, 32'd0);
        chk("rst_instrF", instrF, 32'd0);
        chk("rst_fchange", F_change, 32'd0);
        chk("rst_aerr", 32'(addr_errF), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'(S_REQ));

        resetn = 1'b1;
        #1;
        chk("boot_req", 32'(inst_req), 32'd1);
        chk("boot_addr", inst_addr, 32'hBFC0_0000);

        // Straight-line fetches with varied bus latency and decode stalls.
        for (int i = 0; i < 4; i++) begin
            do_fetch(vecs[i].pc, vecs[i].delay, vecs[i].stall, 1'b0, 1'b0, 32'd0);
            chk("next_req", 32'(inst_req), 32'd1);
            chk("next_addr", inst_addr, vecs[i].next);
        end

        // Taken branch at 0x100: delay slot 0x104 flagged, then jump to 0x200.
        pulse_exc(1'b1, 32'h0000_0100, 1'b0, 32'd0);
        chk("exc_addr_100", inst_addr, 32'h0000_0100);
        do_fetch(32'h0000_0100, 1, 0, 1'b0, 1'b0, 32'd0);
        do_fetch(32'h0000_0104, 1, 0, 1'b1, 1'b1, 32'h0000_0200);
        chk("dslot_flag", F_change, 32'd1);
        chk("br_target", inst_addr, 32'h0000_0200);
        do_fetch(32'h0000_0200, 1, 0, 1'b0, 1'b0, 32'd0);
        chk("after_br_addr", inst_addr, 32'h0000_0204);

        // Exception while waiting: in-flight data swallowed.
        req_q.push_back(32'h0000_0204);
        data_delay = 3;
        addr_ok_en = 1'b1;
        tick();
        addr_ok_en = 1'b0;
        chk("wait_state", 32'(o_dbg_state), 32'(S_WAIT));
        pulse_exc(1'b0, 32'd0, 1'b0, 32'd0);
        wait_data_ok();
        tick();
        chk("drop_valid", 32'(instr_validF), 32'd0);
        chk("drop_instr", instrF, 32'd0);
        chk("exc_req", 32'(inst_req), 32'd1);
        chk("exc_entry_addr", inst_addr, 32'hBFC0_0380);

        // eret-style target with a simultaneous taken branch that must be dropped.
        pulse_exc(1'b1, 32'h8000_0010, 1'b1, 32'h0000_0300);
        chk("eret_addr", inst_addr, 32'h8000_0010);
        do_fetch(32'h8000_0010, 1, 0, 1'b1, 1'b0, 32'd0);
        chk("br_dropped_addr", inst_addr, 32'h8000_0014);

        // Misaligned redirect: bubble with AdEL, no bus request.
        pulse_exc(1'b1, 32'h0000_0202, 1'b0, 32'd0);
        chk("mis_no_req", 32'(inst_req), 32'd0);
        addr_ok_en = 1'b1;
        tick();
        chk("mis_aerr", 32'(addr_errF), 32'd1);
        chk("mis_instr", instrF, 32'd0);
        chk("mis_pcF", pcF, 32'h0000_0202);
        chk("mis_valid", 32'(instr_validF), 32'd0);
        chk("mis_still_no_req", 32'(inst_req), 32'd0);
        addr_ok_en = 1'b0;
        pulse_exc(1'b0, 32'd0, 1'b0, 32'd0);
        chk("mis_recover_aerr", 32'(addr_errF), 32'd0);
        chk("mis_recover_addr", inst_addr, 32'hBFC0_0380);

        // Reset in the middle of an outstanding request.
        req_q.push_back(32'hBFC0_0380);
        data_delay = 1;
        addr_ok_en = 1'b1;
        tick();
        addr_ok_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mid_rst_state", 32'(o_dbg_state), 32'(S_REQ));
        chk("mid_rst_req", 32'(inst_req), 32'd0);
        chk("mid_rst_pcF", pcF, 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        chk("mid_rst_addr", inst_addr, 32'hBFC0_0000);
        tick();
        tick();

        chk("exp_q_left", 32'(exp_q.size()), 32'd0);
        chk("req_q_left", 32'(req_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
